// File: rtl/bnn_load_streamer.sv
// Serializes one captured 28x28 binary image and eight 3x3 binary kernels onto
// the pixel/weight load lines, LSB first, with a write enable delayed by PIPE_LAT.
module bnn_load_streamer #(
    parameter int PIPE_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [783:0] pixels_in,
    input  logic [71:0]  weights_in,
    output logic         d_out_p,
    output logic         d_out_w,
    output logic         en_wr,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [9:0] EN_FIRST = 10'(PIPE_LAT);
    localparam logic [9:0] EN_LAST  = 10'(783 + PIPE_LAT);

    logic [1:0]   r_state;
    logic [9:0]   r_cnt;
    // Bit 0 of each vector goes straight into the output register at capture,
    // so the shift registers hold only the remaining bits.
    logic [782:0] r_pix;
    logic [70:0]  r_wgt;

    logic [9:0]   w_cnt_nx;
    logic         w_last;
    logic         w_en_nx;

    assign w_cnt_nx = r_cnt + 10'd1;
    assign w_last   = (r_cnt == EN_LAST);
    assign w_en_nx  = (w_cnt_nx >= EN_FIRST) && (w_cnt_nx <= EN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 10'd0;
            r_pix   <= '0;
            r_wgt   <= '0;
            d_out_p <= 1'b0;
            d_out_w <= 1'b0;
            en_wr   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    d_out_p <= 1'b0;
                    d_out_w <= 1'b0;
                    en_wr   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    if (start) begin
                        r_pix   <= pixels_in[783:1];
                        r_wgt   <= weights_in[71:1];
                        d_out_p <= pixels_in[0];
                        d_out_w <= weights_in[0];
                        en_wr   <= (EN_FIRST == 10'd0);
                        busy    <= 1'b1;
                        r_cnt   <= 10'd0;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    r_cnt <= w_cnt_nx;
                    if (w_last) begin
                        d_out_p <= 1'b0;
                        d_out_w <= 1'b0;
                        en_wr   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        // Zeros shift in behind the data, so both lines idle low
                        // once their vector is exhausted.
                        d_out_p <= r_pix[0];
                        d_out_w <= r_wgt[0];
                        r_pix   <= {1'b0, r_pix[782:1]};
                        r_wgt   <= {1'b0, r_wgt[70:1]};
                        en_wr   <= w_en_nx;
                    end
                end
                S_DONE: begin
                    d_out_p <= 1'b0;
                    d_out_w <= 1'b0;
                    en_wr   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    d_out_p <= 1'b0;
                    d_out_w <= 1'b0;
                    en_wr   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_load_streamer.sv
// Directed bench for bnn_load_streamer with a one-stage-synchronized loader model.
module tb_bnn_load_streamer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [783:0] pixels_in;
    logic [71:0]  weights_in;
    logic         d_out_p;
    logic         d_out_w;
    logic         en_wr;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_bad;

    bnn_load_streamer #(.PIPE_LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pixels_in  (pixels_in),
        .weights_in (weights_in),
        .d_out_p    (d_out_p),
        .d_out_w    (d_out_w),
        .en_wr      (en_wr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loader model: data through one synchronizer flop, enable used directly.
    logic         ld_clr;
    logic         ld_sp;
    logic         ld_sw;
    int           ld_idx;
    logic [783:0] ld_img;
    logic [71:0]  ld_wgt;

    always @(posedge clk) begin
        ld_sp <= d_out_p;
        ld_sw <= d_out_w;
        if (ld_clr) begin
            ld_idx <= 0;
            ld_img <= '0;
            ld_wgt <= '0;
        end else if (en_wr) begin
            if (ld_idx < 784) ld_img[ld_idx] <= ld_sp;
            if (ld_idx < 72)  ld_wgt[ld_idx] <= ld_sw;
            ld_idx <= ld_idx + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_p"},    32'(d_out_p), 0);
        chk({tag, "_w"},    32'(d_out_w), 0);
        chk({tag, "_en"},   32'(en_wr),   0);
        chk({tag, "_busy"}, 32'(busy),    0);
        chk({tag, "_done"}, 32'(done),    0);
    endtask

    // Returns #1 after edge E, i.e. inside cycle 0.
    task automatic start_xfer();
        @(negedge clk);
        start  = 1'b1;
        ld_clr = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ld_clr = 1'b0;
    endtask

    // Checks cycles 0..787 of a PIPE_LAT=1 transfer; optionally flips pixels_in
    // to all-ones in cycle chg_at and raises start in cycles st_a / st_b.
    task automatic stream_check(input logic [783:0] P, input logic [71:0] W,
                                input int chg_at, input int st_a, input int st_b,
                                input string tag);
        int bp, bw, be, bb, nd, done_at;
        logic ep, ew, ee, eb;
        bp = 0; bw = 0; be = 0; bb = 0; nd = 0; done_at = -1;
        for (int n = 0; n <= 787; n++) begin
            ep = (n < 784) ? P[n] : 1'b0;
            ew = (n < 72)  ? W[n] : 1'b0;
            ee = (n >= 1) && (n <= 784);
            eb = (n <= 784);
            if (d_out_p !== ep) bp++;
            if (d_out_w !== ew) bw++;
            if (en_wr   !== ee) be++;
            if (busy    !== eb) bb++;
            if (done === 1'b1) begin
                nd++;
                done_at = n;
            end
            if (n == chg_at) pixels_in = '1;
            start = (n == st_a) || (n == st_b);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, "_pix_err"},  32'(bp), 0);
        chk({tag, "_wgt_err"},  32'(bw), 0);
        chk({tag, "_en_err"},   32'(be), 0);
        chk({tag, "_busy_err"}, 32'(bb), 0);
        chk({tag, "_ndone"},    32'(nd), 1);
        chk({tag, "_done_cyc"}, 32'(done_at), 785);
    endtask

    task automatic loader_check(input logic [783:0] P, input logic [71:0] W, input string tag);
        chk({tag, "_ld_cnt"},  32'(ld_idx), 784);
        chk({tag, "_ld_img"},  32'($countones(ld_img ^ P)), 0);
        chk({tag, "_ld_wgt"},  32'($countones(ld_wgt ^ W)), 0);
    endtask

    logic [783:0] p_cb;
    logic [783:0] p_rnd;
    logic [71:0]  w_rnd;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        ld_clr = 1'b1;
        pixels_in = '0;
        weights_in = '0;
        for (int i = 0; i < 784; i++) p_cb[i] = ((i / 28) + (i % 28)) % 2 == 1;
        for (int i = 0; i < 784; i++) p_rnd[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 72; i++)  w_rnd[i] = 1'($urandom_range(0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst");

        // reset and start together: reset wins
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        ld_clr = 1'b0;
        chk_idle("rst_start");
        @(posedge clk);
        #1;
        chk("rst_start_busy2", 32'(busy), 0);

        // checkerboard pixels, one-hot weight at bit 40
        pixels_in = p_cb;
        weights_in = 72'd1 << 40;
        start_xfer();
        stream_check(p_cb, 72'd1 << 40, -1, -1, -1, "cb");
        loader_check(p_cb, 72'd1 << 40, "cb");

        // random loopback
        pixels_in = p_rnd;
        weights_in = w_rnd;
        start_xfer();
        stream_check(p_rnd, w_rnd, -1, -1, -1, "rnd");
        loader_check(p_rnd, w_rnd, "rnd");

        // extra starts in STREAM (cycle 10) and DONE (cycle 785) are ignored
        pixels_in = ~p_cb;
        weights_in = ~w_rnd;
        start_xfer();
        stream_check(~p_cb, ~w_rnd, -1, 10, 785, "busy");
        pixels_in = p_rnd;
        weights_in = w_rnd;
        start_xfer();
        stream_check(p_rnd, w_rnd, -1, -1, -1, "busy2");
        loader_check(p_rnd, w_rnd, "busy2");

        // inputs changed after capture have no effect
        pixels_in = '0;
        weights_in = '0;
        start_xfer();
        stream_check('0, '0, 5, -1, -1, "cap");

        // reset in cycle 400 aborts; outputs zero from cycle 401, no done
        pixels_in = p_cb;
        weights_in = w_rnd;
        start_xfer();
        repeat (400) begin
            @(posedge clk);
            #1;
        end
        chk("mid_busy400", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_idle("mid401");
        begin
            int nb, ndn;
            nb = 0;
            ndn = 0;
            for (int n = 0; n < 450; n++) begin
                if (busy === 1'b1) nb++;
                if (done === 1'b1) ndn++;
                @(posedge clk);
                #1;
            end
            chk("mid_busy_after", 32'(nb), 0);
            chk("mid_done_after", 32'(ndn), 0);
        end
        pixels_in = ~p_rnd;
        weights_in = ~w_rnd;
        start_xfer();
        stream_check(~p_rnd, ~w_rnd, -1, -1, -1, "restart");
        loader_check(~p_rnd, ~w_rnd, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
